// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM state type and configuration helpers for multiply_seq
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Bit b set means b bits retired per cycle is a supported step size.
    localparam logic [4:0] MULT_BPC_LEGAL = 5'b10110;

    function automatic int mult_cnt_w(int width, int bpc);
        return $clog2(width / bpc + 1);
    endfunction

    function automatic bit mult_cfg_ok(int width, int bpc);
        if (bpc < 1 || bpc > 4) return 1'b0;
        return MULT_BPC_LEGAL[bpc[2:0]] && (width >= 4) && (width % 2 == 0) && (width % bpc == 0);
    endfunction

endpackage

// File: rtl/multiply_seq_step.sv
// rtl/multiply_seq_step.sv - one BPC-bit partial product added into the 2W accumulator
module multiply_seq_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [BPC-1:0]     mr_bits_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        for (int b = 0; b < BPC; b++) begin
            if (mr_bits_i[b]) pp = pp + (mcand_i << b);
        end
        acc_o = acc_i + pp;
    end

endmodule

// File: rtl/multiply_seq.sv
// rtl/multiply_seq.sv - multi-cycle magnitude multiplier with sign fix; MULT_EARLY_EXIT_EN ends RUN once the multiplier is exhausted
module multiply_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mult_begin,
    input  logic               mult_signed,
    input  logic [WIDTH-1:0]   mult_op1,
    input  logic [WIDTH-1:0]   mult_op2,
    output logic [2*WIDTH-1:0] product,
    output logic               mult_end,
    output logic               mult_busy
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = mult_cnt_w(WIDTH, BPC);
    localparam int W2 = 2 * WIDTH;

    generate
        if (!mult_cfg_ok(WIDTH, BPC)) begin : g_bad_cfg
            $error("multiply_seq: unsupported WIDTH/BPC combination");
        end
    endgenerate

    mult_state_t     state_q, state_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mr_q, mr_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [W2-1:0]   product_q, product_d;

    logic [WIDTH-1:0] op1_mag, op2_mag, mr_shift;
    logic [W2-1:0]    acc_step;
    logic             last_step;

    assign op1_mag  = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
    assign op2_mag  = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;
    assign mr_shift = mr_q >> BPC;

`ifdef MULT_EARLY_EXIT_EN
    assign last_step = (cnt_q == CW'(1)) || (mr_shift == '0);
`else
    assign last_step = (cnt_q == CW'(1));
`endif

    multiply_seq_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .mcand_i   (mcand_q),
        .mr_bits_i (mr_q[BPC-1:0]),
        .acc_i     (acc_q),
        .acc_o     (acc_step)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mr_d      = mr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (mult_begin) begin
                    state_d = RUN;
                    mcand_d = {{WIDTH{1'b0}}, op1_mag};
                    mr_d    = op2_mag;
                    acc_d   = '0;
                    cnt_d   = CW'(N);
                    neg_d   = mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
                end
            end
            RUN: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << BPC;
                mr_d    = mr_shift;
                cnt_d   = cnt_q - CW'(1);
                // Result lands with the DONE transition so it is valid alongside mult_end.
                if (last_step) begin
                    state_d   = DONE;
                    product_d = neg_q ? -acc_step : acc_step;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mr_q      <= mr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign product   = product_q;
    assign mult_end  = (state_q == DONE);
    assign mult_busy = (state_q != IDLE);

endmodule

// File: tb/tb_multiply_seq.sv
// tb/tb_multiply_seq.sv - directed vectors against BPC=1/2/4 instances of multiply_seq
module tb_multiply_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        mult_begin;
    logic        mult_signed;
    logic [31:0] op1, op2;
    logic [63:0] prod [3];
    logic [2:0]  end_v, busy_v;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multiply_seq #(.WIDTH(32), .BPC(1)) u_b1 (
        .clk(clk), .rst(rst), .mult_begin(mult_begin), .mult_signed(mult_signed),
        .mult_op1(op1), .mult_op2(op2), .product(prod[0]), .mult_end(end_v[0]), .mult_busy(busy_v[0]));
    multiply_seq #(.WIDTH(32), .BPC(2)) u_b2 (
        .clk(clk), .rst(rst), .mult_begin(mult_begin), .mult_signed(mult_signed),
        .mult_op1(op1), .mult_op2(op2), .product(prod[1]), .mult_end(end_v[1]), .mult_busy(busy_v[1]));
    multiply_seq #(.WIDTH(32), .BPC(4)) u_b4 (
        .clk(clk), .rst(rst), .mult_begin(mult_begin), .mult_signed(mult_signed),
        .mult_op1(op1), .mult_op2(op2), .product(prod[2]), .mult_end(end_v[2]), .mult_busy(busy_v[2]));

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s bpc=%0d: got %h want %h", name, 1 << d, act, exp);
        end
    endtask

    function automatic int exp_lat(input int d, input logic sgn, input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int bpc;
        int bits;
        int l;
        logic [31:0] m;
        bpc  = 1 << d;
        m    = (sgn && b[31]) ? -b : b;
        bits = 0;
        for (int i = 0; i < 32; i++) if (m[i]) bits = i + 1;
        l = (bits + bpc - 1) / bpc + 1;
        return (l < 2) ? 2 : l;
`else
        return 32 / (1 << d) + 1;
`endif
    endfunction

    // Runs one operation on all three instances; optionally pulses a foreign mult_begin mid-RUN.
    task automatic run_vec(input vec_t v, input int pulse_at);
        int first [3];
        int cnt [3];
        int lat [3];
        logic busy_ok [3];
        for (int d = 0; d < 3; d++) begin
            first[d] = 0; cnt[d] = 0; busy_ok[d] = 1'b1;
            lat[d] = exp_lat(d, v.sgn, v.b);
        end
        @(negedge clk);
        mult_begin = 1'b1; mult_signed = v.sgn; op1 = v.a; op2 = v.b;
        @(posedge clk);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (end_v[d]) begin
                    cnt[d]++;
                    if (first[d] == 0) first[d] = c;
                end
                if (busy_v[d] !== (c <= lat[d])) busy_ok[d] = 1'b0;
            end
            if (c == 1 || c == pulse_at + 1) begin
                mult_begin = 1'b0; op1 = $urandom; op2 = $urandom; mult_signed = 1'($urandom_range(0, 1));
            end
            if (pulse_at != 0 && c == pulse_at) begin
                mult_begin = 1'b1; mult_signed = 1'b0; op1 = 32'd5; op2 = 32'd3;
            end
        end
        for (int d = 0; d < 3; d++) begin
            check("latency", d, 64'(first[d]), 64'(lat[d]));
            check("end_count", d, 64'(cnt[d]), 64'd1);
            check("busy_window", d, 64'(busy_ok[d]), 64'd1);
            check("product", d, prod[d], v.p);
        end
    endtask

    task automatic reset_mid();
        int cnt [3];
        logic busy_seen [3];
        for (int d = 0; d < 3; d++) begin cnt[d] = 0; busy_seen[d] = 1'b0; end
        @(negedge clk);
        mult_begin = 1'b1; mult_signed = 1'b1; op1 = 32'hFFFFFFF9; op2 = 32'h80000001;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) mult_begin = 1'b0;
            for (int d = 0; d < 3; d++) if (end_v[d]) cnt[d]++;
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_mid_product", d, prod[d], 64'd0);
            check("rst_mid_busy", d, 64'(busy_v[d]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (end_v[d]) cnt[d]++;
                if (busy_v[d]) busy_seen[d] = 1'b1;
            end
        end
        for (int d = 0; d < 3; d++) begin
            check("rst_mid_no_end", d, 64'(cnt[d]), 64'd0);
            check("rst_mid_idle", d, 64'(busy_seen[d]), 64'd0);
        end
    endtask

    task automatic back_to_back();
        int t [3][3];
        int k [3];
        int lat [3];
        for (int d = 0; d < 3; d++) begin
            k[d] = 0; lat[d] = exp_lat(d, 1'b0, 32'h80000001);
            for (int j = 0; j < 3; j++) t[d][j] = 0;
        end
        @(negedge clk);
        mult_begin = 1'b1; mult_signed = 1'b0; op1 = 32'd3; op2 = 32'h80000001;
        @(posedge clk);
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (end_v[d] && k[d] < 3) begin t[d][k[d]] = c; k[d]++; end
            end
        end
        mult_begin = 1'b0;
        repeat (40) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("b2b_count", d, 64'(k[d]), 64'd3);
            check("b2b_first", d, 64'(t[d][0]), 64'(lat[d]));
            check("b2b_gap1", d, 64'(t[d][1] - t[d][0]), 64'(lat[d] + 1));
            check("b2b_gap2", d, 64'(t[d][2] - t[d][1]), 64'(lat[d] + 1));
            check("b2b_product", d, prod[d], 64'h0000000180000003);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'hFFFFFFF9, 32'd6,        64'hFFFFFFFFFFFFFFD6};
        vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        vecs[3]  = '{1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000};
        vecs[5]  = '{1'b1, 32'hFFFFFFF9, 32'd0,        64'h0000000000000000};
        vecs[6]  = '{1'b0, 32'h12345678, 32'd5,        64'h000000005B05B058};
        vecs[7]  = '{1'b1, 32'd3,        32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFD};
        vecs[8]  = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
        vecs[10] = '{1'b0, 32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF};
        vecs[11] = '{1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'h0000000000000006};

        rst = 1'b1; mult_begin = 1'b0; mult_signed = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_product", d, prod[d], 64'd0);
            check("reset_end", d, 64'(end_v[d]), 64'd0);
            check("reset_busy", d, 64'(busy_v[d]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 0);

        run_vec('{1'b1, 32'hFFFFFFF9, 32'h80000001, 64'h000000037FFFFFF9}, 4);
        back_to_back();
        reset_mid();
        run_vec(vecs[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multiply_seq.md
# multiply_seq

Parametrised multi-cycle multiplier: the sequential successor to the single-cycle 32-bit signed multiplier. It keeps the `mult_begin`/`mult_end` handshake and magnitude-then-sign-fix method. It adds configurable operand width, configurable bits retired per cycle, and a per-operation signed/unsigned mode. It sits beside the ALU in the execute stage, and the control unit stalls on `mult_busy` until `mult_end`.

## Interface
- `WIDTH`, default 32: operand width. Must be even and at least 4.
- `BPC`, default 1: multiplier bits retired per cycle. Legal values are 1, 2 and 4, and `WIDTH % BPC == 0`.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: reset, **asynchronous and active-high**. All state clears while it is high.
- `mult_begin`, input, 1: start request. Sampled only in IDLE.
- `mult_signed`, input, 1: 1 treats both operands as two's complement, 0 as unsigned. Sampled with `mult_begin`.
- `mult_op1`, input, WIDTH: multiplicand. Sampled with `mult_begin`.
- `mult_op2`, input, WIDTH: multiplier. Sampled with `mult_begin`.
- `product`, output, 2*WIDTH: registered result. Held stable from `mult_end` until the next `mult_end`.
- `mult_end`, output, 1: one-cycle completion pulse.
- `mult_busy`, output, 1: high from the cycle after accept through the `mult_end` cycle.

## Operation
- FSM states:
  - IDLE: on `mult_begin`=1, go to RUN.
  - RUN: after `N = WIDTH/BPC` steps, go to DONE.
  - DONE: always go to IDLE after one cycle.
- Accept (IDLE with `mult_begin`=1):
  - Latch `|op1|` and `|op2|`. Magnitude is two's-complement negation when `mult_signed` and the MSB is 1; otherwise the raw value.
  - Latch `neg = mult_signed & (op1[W-1] ^ op2[W-1])`.
  - Clear the 2W-bit accumulator. Load the step counter with N.
- RUN step:
  - `acc += (|op1| * mr[BPC-1:0]) << shift`.
  - Then `mr >>= BPC`, `shift += BPC`, counter decrements.
  - All arithmetic is unsigned and 2W bits wide. No overflow is possible.
- DONE:
  - `product <= neg ? (~acc + 1) : acc`. `mult_end`=1 for exactly this cycle.
- Most-negative operand: `|-2^(W-1)|` = `2^(W-1)` fits in W unsigned bits. Signed (min × min) = `2^(2W-2)`, positive.
- Zero result with `neg`=1: negation of 0 yields 0. No negative zero.
- `mult_begin` in RUN or DONE is ignored. There is no queueing.
- `mult_begin` held high through DONE is accepted in the following IDLE cycle.
- Operand inputs are don't-care outside the accept cycle.
- Reset:
  - Reset values: FSM=IDLE, `product`=0, `mult_end`=0, `mult_busy`=0, accumulator and counter 0.
  - Reset asserted mid-operation aborts it. No `mult_end` is produced for the aborted operation.

## Timing
- Accept on the rising edge at cycle k.
- RUN occupies cycles k+1 .. k+N.
- `mult_end`=1 and the new `product` are valid in cycle k+N+1.
- Latency: N+1 cycles; 33 for W=32/BPC=1, 17 for BPC=2, 9 for BPC=4.
- Throughput: at most one operation per N+2 cycles (DONE → IDLE → accept).
- `mult_busy` is high in cycles k+1 .. k+N+1.

## Configuration
- `MULT_EARLY_EXIT_EN` defined:
  - In RUN, if the remaining multiplier after the current step is zero, the next state is DONE regardless of the counter.
  - Latency becomes `ceil((msb_index(|op2|)+1)/BPC)+1`, with a minimum of 2 (zero multiplier: one RUN cycle, `mult_end` at k+2).
  - Results are bit-identical to the fixed-latency build.
- Undefined: fixed latency of N+1 for every operation. The early-exit comparator is absent.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` {IDLE, RUN, DONE};
  - legal-BPC check constant;
  - `mult_cnt_w(WIDTH,BPC)` width function.
- One sub-module `multiply_seq_step`: combinational BPC-bit partial product plus 2W accumulate. It is instantiated once.
- Top level holds the FSM, operand/magnitude registers and the sign fix.

## Test plan
- W=32, BPC=1, signed: `op1=-7` (0xFFFFFFF9), `op2=6` → `product=0xFFFFFFFFFFFFFFD6` (-42); `mult_end` exactly at k+33; `mult_busy` high k+1..k+33.
- W=32, BPC=2, unsigned: `0xFFFFFFFF × 0xFFFFFFFF` → `0xFFFFFFFE00000001` at k+17. The same operands signed give `0x0000000000000001`.
- W=32, BPC=4, signed: `0x80000000 × 0x80000000` → `0x4000000000000000`. `0x80000000 × 0xFFFFFFFF` → `0x0000000080000000`.
- Handshake:
  - `mult_begin` pulsed during RUN with other operands → ignored, first result unchanged.
  - `mult_begin` held high continuously → back-to-back results spaced N+2 cycles apart.
- Reset at k+10 of a BPC=1 op → `product`=0, `mult_busy`=0, no `mult_end`. A new op after release completes normally.
- `MULT_EARLY_EXIT_EN`, BPC=1: `op2=0` → `product=0` at k+2. `op2=5` → `mult_end` at k+4. `op2=-1` signed (|op2|=1) → `product=-op1` at k+2.
